flame_scheduler: RTL and testbench
==================================

// Module: flame_scheduler
// PURPOSE
//  Owns up to NSLOT concurrent bomb explosions and drives the flame sprite renderer: accepts detonation
//  requests (centre tile + range), animates each through NSTEPS sprite frames paced by new_frame, and per
//  pixel resolves which explosion covers the current tile -> centerXF/centerYF/sprite_num for the renderer.
//  Sits between game logic (bomb timers) and the flame sprite/pixel mux in the 800x600 display path.
// PARAMETERS
//  NSLOT       4   explosion slots (1..8)
//  FRAME_TICKS 8   new_frame pulses per animation step (>=1)
//  NSTEPS      4   animation steps = sprite frames, sprite_num 0..NSTEPS-1 (<=4)
//  GRID_W      25  playfield width in 32-px tiles
//  GRID_H      18  playfield height in 32-px tiles
//  ORIGIN_X    0   playfield left edge, px (signed)
//  ORIGIN_Y    0   playfield top edge, px (signed)
// PORTS
//  clk         in   1   pixel clock; single clock domain
//  reset_n     in   1   asynchronous, active-low reset
//  new_frame   in   1   1-cycle pulse at start of vertical blanking
//  req_valid   in   1   detonation request
//  req_ready   out  1   high when >=1 slot IDLE
//  req_tileX   in   5   centre tile column
//  req_tileY   in   5   centre tile row
//  req_range   in   2   arm length in tiles (0 = centre only)
//  req_err     out  1   1-cycle pulse: accepted request had tile outside grid (dropped)
//  spotX/spotY in   11s current pixel coordinates
//  centerXF    out  11s top-left px of covering tile (renderer origin)
//  centerYF    out  11s
//  sprite_num  out  2   animation step of covering explosion
//  flame_on    out  1   current pixel lies in a burning flame tile
//  done_mask   out  NSLOT 1-cycle pulse, bit i = slot i retired
//  active_cnt  out  4   number of non-IDLE slots
// BEHAVIOUR
//  Reset: all slots IDLE, tick/step=0; flame_on=0, centerXF=centerYF=-64, sprite_num=0, done_mask=0,
//   req_err=0, active_cnt=0, req_ready=1. Reset mid-burn drops all explosions; no done pulse emitted.
//  Slot FSM: IDLE -(accept)-> ARMED -(new_frame)-> BURN(step0,tick0) -> IDLE after NSTEPS*FRAME_TICKS frames.
//  Accept = req_valid & req_ready; stores into lowest-index IDLE slot. req_ready is comb. on slot state.
//   Out-of-grid tile (tileX>=GRID_W or tileY>=GRID_H): handshake completes, no slot used, req_err next cycle.
//  ARMED is invisible to lookup; visibility changes only at new_frame (no mid-frame tearing).
//  new_frame, per BURN slot: tick==FRAME_TICKS-1 ? (tick=0, step++) : tick++; if step==NSTEPS-1 when
//   tick wraps -> IDLE, bit set in done_mask on next cycle. ARMED->BURN on that same pulse is not advanced.
//  Accept and new_frame same cycle: slot becomes ARMED; goes BURN on the following new_frame.
//  Accept into slot retiring same cycle not possible (slot is not IDLE until after retirement).
//  Lookup: tx=(spotX-ORIGIN_X)>>>5, ty=(spotY-ORIGIN_Y)>>>5; spot outside [0,GRID_W)x[0,GRID_H) -> no hit.
//   Slot hits if BURN and ((tx==cx && |ty-cy|<=range) || (ty==cy && |tx-cx|<=range)); cross shape only.
//   Lowest-index hitting slot wins. Outputs registered: 1-cycle latency from spotX/spotY.
//   Hit: flame_on=1, centerXF=ORIGIN_X+tx*32, centerYF=ORIGIN_Y+ty*32, sprite_num=step.
//   Miss: flame_on=0, centerXF=centerYF=-64 (renderer window never matches), sprite_num=0.
//  Arithmetic: signed 11-bit; |d| computed on 6-bit signed tile differences, no wrap at grid edges.
//  active_cnt registered, counts ARMED+BURN.
// TESTING
//  Reset: hold reset_n=0 -> flame_on=0, centerXF=-64, req_ready=1, active_cnt=0; release, outputs stable.
//  Req (3,4) r=1; before new_frame spot(96,128)->flame_on=0; after: (96,128) hit centre (96,128) step0;
//   (128,128),(96,96) hit; (160,128) miss; diagonal (128,160) miss; (-5,128) miss.
//  Animate: sprite_num 0->1 after 8 new_frames; after 32 new_frames from BURN done_mask=4'b0001, active_cnt 0.
//  Full: 4 accepts -> req_ready=0, 5th req held; on first retirement req_ready=1, held req takes freed slot.
//  Overlap: slot0 step2 and slot1 step0 cover (5,5) -> sprite_num=2; req (30,2) -> req_err pulse, no slot.
//  Corners: req with new_frame same cycle stays ARMED one frame; reset_n low mid-burn -> all IDLE, no done.

Source files
------------

// File: rtl/flame_scheduler_if.sv
// Detonation request handshake between game logic (master) and the flame scheduler (slave).
interface flame_scheduler_if;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_tileX;
  logic [4:0] req_tileY;
  logic [1:0] req_range;
  logic       req_err;

  modport master (
    output req_valid, req_tileX, req_tileY, req_range,
    input  req_ready, req_err
  );

  modport slave (
    input  req_valid, req_tileX, req_tileY, req_range,
    output req_ready, req_err
  );
endinterface

// File: rtl/flame_scheduler.sv
// Explosion slot manager: animates up to NSLOT cross-shaped flames paced by new_frame and
// resolves, per pixel, which burning slot covers the current tile for the flame sprite renderer.
module flame_scheduler #(
  parameter int        NSLOT       = 4,
  parameter int        FRAME_TICKS = 8,
  parameter int        NSTEPS      = 4,
  parameter int        GRID_W      = 25,
  parameter int        GRID_H      = 18,
  parameter int signed ORIGIN_X    = 0,
  parameter int signed ORIGIN_Y    = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     new_frame,
  flame_scheduler_if.slave         req,
  input  logic signed [10:0]       spotX,
  input  logic signed [10:0]       spotY,
  output logic signed [10:0]       centerXF,
  output logic signed [10:0]       centerYF,
  output logic [1:0]               sprite_num,
  output logic                     flame_on,
  output logic [NSLOT-1:0]         done_mask,
  output logic [3:0]               active_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_BURN  = 2'd2;

  localparam int                TW        = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(FRAME_TICKS - 1);
  localparam logic [1:0]        STEP_LAST = 2'(NSTEPS - 1);
  localparam logic signed [10:0] MISS_POS = -11'sd64;
  localparam logic signed [10:0] OX       = 11'(ORIGIN_X);
  localparam logic signed [10:0] OY       = 11'(ORIGIN_Y);

  logic [1:0]    st   [NSLOT];
  logic [4:0]    cx   [NSLOT];
  logic [4:0]    cy   [NSLOT];
  logic [1:0]    rng  [NSLOT];
  logic [TW-1:0] tick [NSLOT];
  logic [1:0]    step [NSLOT];

  logic [1:0]    nst   [NSLOT];
  logic [TW-1:0] ntick [NSLOT];
  logic [1:0]    nstep [NSLOT];
  logic [NSLOT-1:0] retire;
  logic [NSLOT-1:0] alloc;
  logic [3:0]    cnt_next;
  logic          free_any, accept, tile_ok, store;

  // Lowest-index IDLE slot receives the next accepted request.
  always_comb begin
    free_any = 1'b0;
    alloc    = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (st[i] == S_IDLE && !free_any) begin
        alloc[i] = 1'b1;
        free_any = 1'b1;
      end
    end
  end

  assign req.req_ready = free_any;
  assign accept  = req.req_valid & free_any;
  assign tile_ok = ({1'b0, req.req_tileX} < 6'(GRID_W)) && ({1'b0, req.req_tileY} < 6'(GRID_H));
  assign store   = accept & tile_ok;

  always_comb begin
    cnt_next = '0;
    retire   = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      nst[i]   = st[i];
      ntick[i] = tick[i];
      nstep[i] = step[i];
      if (new_frame) begin
        if (st[i] == S_ARMED) begin
          nst[i]   = S_BURN;
          ntick[i] = '0;
          nstep[i] = '0;
        end else if (st[i] == S_BURN) begin
          if (tick[i] == TICK_LAST) begin
            ntick[i] = '0;
            if (step[i] == STEP_LAST) begin
              nst[i]    = S_IDLE;
              retire[i] = 1'b1;
            end else begin
              nstep[i] = step[i] + 2'd1;
            end
          end else begin
            ntick[i] = tick[i] + TW'(1);
          end
        end
      end
      // The allocated slot is IDLE, so new_frame never touches it in the same cycle.
      if (store && alloc[i]) begin
        nst[i]   = S_ARMED;
        ntick[i] = '0;
        nstep[i] = '0;
      end
      cnt_next = cnt_next + 4'(nst[i] != S_IDLE);
    end
  end

  logic signed [10:0] rel_x, rel_y, tile_x, tile_y;
  logic signed [5:0]  tx6, ty6;
  logic               spot_in, hit;
  logic [1:0]         hit_step;
  logic signed [10:0] hit_x, hit_y;

  assign rel_x   = spotX - OX;
  assign rel_y   = spotY - OY;
  assign tile_x  = rel_x >>> 5;
  assign tile_y  = rel_y >>> 5;
  assign tx6     = tile_x[5:0];
  assign ty6     = tile_y[5:0];
  assign spot_in = !tile_x[10] && !tile_y[10] &&
                   (tile_x < $signed(11'(GRID_W))) && (tile_y < $signed(11'(GRID_H)));
  assign hit_x   = OX + $signed({tile_x[5:0], 5'b0});
  assign hit_y   = OY + $signed({tile_y[5:0], 5'b0});

  always_comb begin
    logic signed [5:0] dx, dy, adx, ady;
    logic on_col, on_row;
    hit      = 1'b0;
    hit_step = '0;
    dx = '0; dy = '0; adx = '0; ady = '0;
    on_col = 1'b0; on_row = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      dx     = tx6 - $signed({1'b0, cx[i]});
      dy     = ty6 - $signed({1'b0, cy[i]});
      adx    = dx[5] ? -dx : dx;
      ady    = dy[5] ? -dy : dy;
      on_col = (dx == 6'sd0) && (ady <= $signed({4'b0, rng[i]}));
      on_row = (dy == 6'sd0) && (adx <= $signed({4'b0, rng[i]}));
      if (!hit && spot_in && st[i] == S_BURN && (on_col || on_row)) begin
        hit      = 1'b1;
        hit_step = step[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        st[i]   <= S_IDLE;
        cx[i]   <= '0;
        cy[i]   <= '0;
        rng[i]  <= '0;
        tick[i] <= '0;
        step[i] <= '0;
      end
      flame_on    <= 1'b0;
      centerXF    <= MISS_POS;
      centerYF    <= MISS_POS;
      sprite_num  <= '0;
      done_mask   <= '0;
      req.req_err <= 1'b0;
      active_cnt  <= '0;
    end else begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        st[i]   <= nst[i];
        tick[i] <= ntick[i];
        step[i] <= nstep[i];
        if (store && alloc[i]) begin
          cx[i]  <= req.req_tileX;
          cy[i]  <= req.req_tileY;
          rng[i] <= req.req_range;
        end
      end
      done_mask   <= retire;
      req.req_err <= accept & ~tile_ok;
      active_cnt  <= cnt_next;
      flame_on    <= hit;
      centerXF    <= hit ? hit_x : MISS_POS;
      centerYF    <= hit ? hit_y : MISS_POS;
      sprite_num  <= hit ? hit_step : 2'd0;
    end
  end

endmodule

// File: tb/tb_flame_scheduler.sv
// Bench for flame_scheduler: directed scenarios plus random traffic against a frame-count model.
module tb_flame_scheduler;
  localparam int NSLOT = 4;
  localparam int FT    = 8;
  localparam int NST   = 4;
  localparam int GW    = 25;
  localparam int GH    = 18;
  localparam int OX    = 0;
  localparam int OY    = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic new_frame = 1'b0;
  logic signed [10:0] spotX = '0, spotY = '0;
  logic signed [10:0] centerXF, centerYF;
  logic [1:0] sprite_num;
  logic flame_on;
  logic [NSLOT-1:0] done_mask;
  logic [3:0] active_cnt;

  flame_scheduler_if bus ();

  flame_scheduler #(
    .NSLOT(NSLOT), .FRAME_TICKS(FT), .NSTEPS(NST), .GRID_W(GW), .GRID_H(GH),
    .ORIGIN_X(OX), .ORIGIN_Y(OY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .new_frame(new_frame), .req(bus),
    .spotX(spotX), .spotY(spotY), .centerXF(centerXF), .centerYF(centerYF),
    .sprite_num(sprite_num), .flame_on(flame_on), .done_mask(done_mask), .active_cnt(active_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Model: 0 idle, 1 armed, 2 burning; m_fr counts new_frames seen while burning.
  int m_st [NSLOT];
  int m_cx [NSLOT];
  int m_cy [NSLOT];
  int m_r  [NSLOT];
  int m_fr [NSLOT];

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void lookup(input int sx, input int sy,
                                 output int fl, output int x, output int y, output int spr);
    int tx, ty;
    tx = (sx - OX) >>> 5;
    ty = (sy - OY) >>> 5;
    fl = 0; x = -64; y = -64; spr = 0;
    if (tx >= 0 && tx < GW && ty >= 0 && ty < GH) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (m_st[s] == 2 &&
            ((tx == m_cx[s] && iabs(ty - m_cy[s]) <= m_r[s]) ||
             (ty == m_cy[s] && iabs(tx - m_cx[s]) <= m_r[s]))) begin
          fl = 1; x = OX + tx * 32; y = OY + ty * 32; spr = m_fr[s] / FT;
          break;
        end
      end
    end
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NSLOT; s++) begin
      m_st[s] = 0; m_cx[s] = 0; m_cy[s] = 0; m_r[s] = 0; m_fr[s] = 0;
    end
  endtask

  // One clock edge: predict from pre-edge state and inputs, then compare every output.
  task automatic clk_step();
    int fl, ex, ey, es, done, alloc, cnt;
    bit rdy, acc, ok;
    lookup(int'(spotX), int'(spotY), fl, ex, ey, es);
    rdy = 0; alloc = -1;
    for (int s = 0; s < NSLOT; s++)
      if (m_st[s] == 0) begin
        rdy = 1;
        if (alloc < 0) alloc = s;
      end
    check("req_ready", bus.req_ready, int'(rdy));
    acc = bus.req_valid && rdy;
    ok  = (int'(bus.req_tileX) < GW) && (int'(bus.req_tileY) < GH);
    done = 0;
    if (new_frame)
      for (int s = 0; s < NSLOT; s++) begin
        if (m_st[s] == 2) begin
          m_fr[s]++;
          if (m_fr[s] == NST * FT) begin
            m_st[s] = 0;
            done |= (1 << s);
          end
        end else if (m_st[s] == 1) begin
          m_st[s] = 2; m_fr[s] = 0;
        end
      end
    if (acc && ok) begin
      m_st[alloc] = 1; m_fr[alloc] = 0;
      m_cx[alloc] = int'(bus.req_tileX); m_cy[alloc] = int'(bus.req_tileY);
      m_r[alloc]  = int'(bus.req_range);
    end
    cnt = 0;
    for (int s = 0; s < NSLOT; s++) if (m_st[s] != 0) cnt++;
    @(posedge clk); #1;
    if (acc) bus.req_valid = 1'b0;
    check("flame_on", flame_on, fl);
    check("centerXF", centerXF, ex);
    check("centerYF", centerYF, ey);
    check("sprite_num", sprite_num, es);
    check("done_mask", done_mask, done);
    check("req_err", bus.req_err, int'(acc && !ok));
    check("active_cnt", active_cnt, cnt);
  endtask

  task automatic set_req(input int x, input int y, input int r);
    bus.req_valid = 1'b1;
    bus.req_tileX = 5'(x);
    bus.req_tileY = 5'(y);
    bus.req_range = 2'(r);
  endtask

  task automatic set_spot(input int x, input int y);
    spotX = 11'(x);
    spotY = 11'(y);
  endtask

  task automatic frame_pulse();
    new_frame = 1'b1; clk_step();
    new_frame = 1'b0; clk_step(); clk_step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    new_frame = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_flame_on", flame_on, 0);
    check("rst_centerXF", centerXF, -64);
    check("rst_centerYF", centerYF, -64);
    check("rst_sprite", sprite_num, 0);
    check("rst_done", done_mask, 0);
    check("rst_err", bus.req_err, 0);
    check("rst_active", active_cnt, 0);
    check("rst_ready", bus.req_ready, 1);
    reset_n = 1'b1;
    clk_step();
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_tileX = '0; bus.req_tileY = '0; bus.req_range = '0;
    model_clear();
    #2;
    do_reset();

    // Single explosion at (3,4), range 1.
    set_req(3, 4, 1); clk_step();
    set_spot(96, 128); clk_step();
    check("pre_frame_miss", flame_on, 0);
    frame_pulse();
    set_spot(96, 128); clk_step();
    check("centre_hit", flame_on, 1);
    check("centre_x", centerXF, 96);
    check("centre_y", centerYF, 128);
    check("centre_step", sprite_num, 0);
    set_spot(128, 128); clk_step(); check("arm_right", flame_on, 1);
    set_spot(96, 96);   clk_step(); check("arm_up", flame_on, 1);
    set_spot(160, 128); clk_step(); check("beyond_range", flame_on, 0);
    set_spot(128, 160); clk_step(); check("diagonal", flame_on, 0);
    set_spot(-5, 128);  clk_step(); check("neg_spot", flame_on, 0);

    // Animation: step advances every FT frames, retirement after NST*FT.
    set_spot(96, 128);
    repeat (7) frame_pulse();
    check("step_before_8", sprite_num, 0);
    frame_pulse();
    check("step_after_8", sprite_num, 1);
    repeat (23) frame_pulse();
    new_frame = 1'b1; clk_step();
    check("retire_done", done_mask, 4'b0001);
    check("retire_active", active_cnt, 0);
    new_frame = 1'b0; clk_step();
    check("done_pulse_ends", done_mask, 0);

    // Full: two slots burn first, two later; a fifth request waits for the first retirement.
    set_req(1, 1, 0); clk_step();
    set_req(2, 2, 0); clk_step();
    frame_pulse();
    set_req(3, 3, 0); clk_step();
    set_req(4, 4, 0); clk_step();
    set_req(6, 6, 2);
    #1 check("full_not_ready", bus.req_ready, 0);
    frame_pulse();
    repeat (30) frame_pulse();
    new_frame = 1'b1; clk_step();
    check("full_retire", done_mask, 4'b0011);
    new_frame = 1'b0; clk_step();
    check("held_accepted_active", active_cnt, 3);
    check("held_valid_dropped", bus.req_valid, 0);
    clk_step();

    // Overlap: slot0 at step 2, slot1 at step 0 both cover (5,5).
    do_reset();
    set_req(5, 5, 0); clk_step();
    frame_pulse();
    repeat (16) frame_pulse();
    set_req(5, 4, 1); clk_step();
    frame_pulse();
    set_spot(160, 160); clk_step();
    check("overlap_hit", flame_on, 1);
    check("overlap_step", sprite_num, 2);
    set_req(30, 2, 1); clk_step();
    check("oob_err", bus.req_err, 1);
    check("oob_active", active_cnt, 2);
    clk_step();
    check("oob_err_clear", bus.req_err, 0);

    // Request coinciding with new_frame stays armed for one frame.
    do_reset();
    set_req(10, 10, 2); new_frame = 1'b1; clk_step();
    new_frame = 1'b0;
    set_spot(320, 320); clk_step(); clk_step();
    check("armed_invisible", flame_on, 0);
    frame_pulse();
    clk_step();
    check("burn_visible", flame_on, 1);
    check("burn_step0", sprite_num, 0);

    // Reset mid-burn: everything drops, no done pulse.
    reset_n = 1'b0;
    #2;
    check("midrst_done", done_mask, 0);
    check("midrst_active", active_cnt, 0);
    check("midrst_flame", flame_on, 0);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      if (!bus.req_valid && $urandom_range(0, 5) == 0)
        set_req(int'($urandom_range(0, 31)), int'($urandom_range(0, 23)), int'($urandom_range(0, 3)));
      new_frame = ($urandom_range(0, 2) == 0);
      begin
        int s;
        s = int'($urandom_range(0, NSLOT - 1));
        if (m_st[s] == 2 && $urandom_range(0, 1) == 1)
          set_spot(OX + m_cx[s] * 32 + (int'($urandom_range(0, 6)) - 3) * 32 + int'($urandom_range(0, 31)),
                   OY + m_cy[s] * 32 + (int'($urandom_range(0, 6)) - 3) * 32 + int'($urandom_range(0, 31)));
        else
          set_spot(int'($urandom_range(0, 890)) - 40, int'($urandom_range(0, 660)) - 40);
      end
      clk_step();
    end
    new_frame = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
